// File: rtl/vpu3_msdp_lanes.sv
// Multi-lane modular "modswitch" datapath: (a - (c - P/2)) * PIMQ (+ b) mod MOD,
// with a fixed-latency non-stalling pipeline feeding a credit-protected output FIFO.
module vpu3_msdp_lanes #(
    parameter P      = 39'h40_0080_0001,
    parameter MOD    = 35'h4_0008_0001,
    parameter IMOD   = 36'd68_717_379_643,
    parameter PIMQ   = 35'd8_017_516_954,
    parameter int DWIDTH = 39,
    parameter int LANES  = 4,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_dp_vld,
    output logic                      o_dp_rdy,
    input  logic [1:0]                i_dp_mode,
    input  logic [LANES*DWIDTH-1:0]   i_dp_dina,
    input  logic [LANES*DWIDTH-1:0]   i_dp_dinb,
    input  logic [LANES*DWIDTH-1:0]   i_dp_dinc,
    output logic                      o_dp_vldout,
    input  logic                      i_dp_rdy,
    output logic [LANES*DWIDTH-1:0]   o_dp_dout,
    output logic                      o_dp_busy,
    output logic                      o_dp_err
);
    localparam int MWIDTH = $clog2(MOD);
    // Stage map: 0 subred, 1 modsub, 2 product, 3 Barrett reduce, 4 add/select.
    localparam int COMMON_MODSUBRED_DELAY = 1;
    localparam int COMMON_MODSUB_DELAY    = 1;
    localparam int COMMON_MODMUL_DELAY    = 2;
    localparam int COMMON_MODADD_DELAY    = 1;
    localparam int L = COMMON_MODSUBRED_DELAY + COMMON_MODSUB_DELAY
                     + COMMON_MODMUL_DELAY + COMMON_MODADD_DELAY;
    localparam int PWIDTH = 2 * MWIDTH;
    localparam int TWIDTH = PWIDTH + MWIDTH + 1;
    localparam int PTRW   = $clog2(DEPTH);
    localparam int CNTW   = $clog2(DEPTH + 1);

    typedef logic [MWIDTH-1:0] m_t;

    localparam logic [MWIDTH:0]   MOD_E  = (MWIDTH+1)'(MOD);
    localparam logic [MWIDTH:0]   IMOD_E = (MWIDTH+1)'(IMOD);
    localparam m_t                PIMQ_M = MWIDTH'(PIMQ);
    localparam logic [DWIDTH-1:0] MOD_D  = DWIDTH'(MOD);
    localparam logic [DWIDTH-1:0] HALF_D = DWIDTH'(P >> 1);
    localparam m_t                HALF_M = MWIDTH'(HALF_D % MOD_D);

    // Full-width lane value reduced into [0, MOD).
    function automatic m_t red_d(input logic [DWIDTH-1:0] v);
        logic [DWIDTH-1:0] r;
        r = v % MOD_D;
        return r[MWIDTH-1:0];
    endfunction

    function automatic m_t mod_sub(input m_t x, input m_t y);
        logic [MWIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[MWIDTH] ? m_t'(d + MOD_E) : d[MWIDTH-1:0];
    endfunction

    function automatic m_t mod_add(input m_t x, input m_t y);
        logic [MWIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= MOD_E) ? m_t'(s - MOD_E) : s[MWIDTH-1:0];
    endfunction

    // Barrett reduction; IMOD = floor(2^(2*MWIDTH)/MOD) keeps the estimate within one MOD.
    function automatic m_t mod_red(input logic [PWIDTH-1:0] p);
        logic [TWIDTH-1:0] t;
        logic [PWIDTH-1:0] q;
        logic [PWIDTH-1:0] r;
        t = TWIDTH'(p) * TWIDTH'(IMOD_E);
        q = PWIDTH'(t >> PWIDTH);
        r = p - q * PWIDTH'(MOD_E);
        r = (r >= PWIDTH'(MOD_E)) ? r - PWIDTH'(MOD_E) : r;
        return r[MWIDTH-1:0];
    endfunction

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}} : p + PTRW'(1);
    endfunction

    // Control state (reset)
    logic [L-1:0]      vld_q, vld_d;
    logic [1:0]        mode_q [L];
    logic [1:0]        mode_d [L];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   occ_q, occ_d, cnt_q, cnt_d;
    logic              err_q, err_d, rdy_q, rdy_d, vldout_q, vldout_d, busy_q, busy_d;
    // Datapath state (no reset)
    m_t                x0_q [LANES], x0_d [LANES];
    m_t                a0_q [LANES], a0_d [LANES];
    m_t                x1_q [LANES], x1_d [LANES];
    logic [PWIDTH-1:0] pr2_q [LANES], pr2_d [LANES];
    m_t                x3_q [LANES], x3_d [LANES];
    m_t                r4_q [LANES], r4_d [LANES];
    m_t                aux_q [4][LANES];
    m_t                aux_d [4][LANES];
    logic [LANES*DWIDTH-1:0] mem_q [DEPTH];
    logic [LANES*DWIDTH-1:0] wdata_s;
    logic              acc_s, wr_s, rd_s;

    // Next-state for pipeline, FIFO bookkeeping, credits and status flags.
    always_comb begin
        acc_s = i_dp_vld & rdy_q;
        wr_s  = vld_q[L-1];
        rd_s  = vldout_q & i_dp_rdy;
        vld_d = {vld_q[L-2:0], acc_s};
        mode_d[0] = i_dp_mode;
        for (int s = 1; s < L; s++) begin
            mode_d[s] = mode_q[s-1];
        end
        for (int s = 1; s < 4; s++) begin
            aux_d[s] = aux_q[s-1];
        end
        wdata_s = {(LANES*DWIDTH){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            x0_d[k]     = mod_sub(red_d(i_dp_dinc[k*DWIDTH +: DWIDTH]), HALF_M);
            a0_d[k]     = red_d(i_dp_dina[k*DWIDTH +: DWIDTH]);
            aux_d[0][k] = i_dp_mode[1] ? i_dp_dina[k*DWIDTH +: MWIDTH]
                                       : red_d(i_dp_dinb[k*DWIDTH +: DWIDTH]);
            x1_d[k]     = mod_sub(a0_q[k], x0_q[k]);
            pr2_d[k]    = PWIDTH'(x1_q[k]) * PWIDTH'(PIMQ_M);
            x3_d[k]     = mod_red(pr2_q[k]);
            case (mode_q[3])
                2'd0:    r4_d[k] = mod_add(x3_q[k], aux_q[3][k]);
                2'd1:    r4_d[k] = x3_q[k];
                default: r4_d[k] = aux_q[3][k];
            endcase
            wdata_s[k*DWIDTH +: DWIDTH] = DWIDTH'(r4_q[k]);
        end
        wr_ptr_d = wr_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({wr_s, rd_s})
            2'b10:   occ_d = occ_q + CNTW'(1);
            2'b01:   occ_d = occ_q - CNTW'(1);
            default: occ_d = occ_q;
        endcase
        case ({acc_s, rd_s})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
        err_d    = err_q | (vld_q[L-1] & (mode_q[L-1] == 2'd3));
        rdy_d    = (cnt_d < CNTW'(DEPTH));
        vldout_d = (occ_d != CNTW'(0));
        busy_d   = (cnt_d != CNTW'(0));
    end

    // Control registers with asynchronous reset; clearing them discards all beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= {L{1'b0}};
            for (int s = 0; s < L; s++) begin
                mode_q[s] <= 2'd0;
            end
            wr_ptr_q <= {PTRW{1'b0}};
            rd_ptr_q <= {PTRW{1'b0}};
            occ_q    <= {CNTW{1'b0}};
            cnt_q    <= {CNTW{1'b0}};
            err_q    <= 1'b0;
            rdy_q    <= 1'b1;
            vldout_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdy_q    <= rdy_d;
            vldout_q <= vldout_d;
            busy_q   <= busy_d;
        end
    end

    // Datapath and FIFO storage; contents are qualified by the valid pipeline.
    always_ff @(posedge clk) begin
        x0_q  <= x0_d;
        a0_q  <= a0_d;
        x1_q  <= x1_d;
        pr2_q <= pr2_d;
        x3_q  <= x3_d;
        r4_q  <= r4_d;
        aux_q <= aux_d;
        if (wr_s) begin
            mem_q[wr_ptr_q] <= wdata_s;
        end
    end

    assign o_dp_rdy    = rdy_q;
    assign o_dp_vldout = vldout_q;
    assign o_dp_busy   = busy_q;
    assign o_dp_err    = err_q;
    assign o_dp_dout   = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_vpu3_msdp_lanes.sv
// Scoreboard bench for vpu3_msdp_lanes: expected words queued on acceptance,
// compared in order when the output handshake fires.
module tb_vpu3_msdp_lanes;
    localparam int DW    = 39;
    localparam int LN    = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 5;
    localparam int WW    = LN * DW;
    typedef logic [WW-1:0] word_t;
    localparam word_t        W0   = {WW{1'b0}};
    localparam logic [127:0] M    = 128'h4_0008_0001;
    localparam logic [127:0] HALF = 128'h20_0040_0000;
    localparam logic [127:0] PQ   = 128'd8_017_516_954;

    logic       clk, rst_n, i_dp_vld, o_dp_rdy, o_dp_vldout, i_dp_rdy, o_dp_busy, o_dp_err;
    logic [1:0] i_dp_mode;
    word_t      i_dp_dina, i_dp_dinb, i_dp_dinc, o_dp_dout;
    word_t      sb [$];
    int         n_cmp, n_fail;

    vpu3_msdp_lanes dut (
        .clk(clk), .rst_n(rst_n), .i_dp_vld(i_dp_vld), .o_dp_rdy(o_dp_rdy),
        .i_dp_mode(i_dp_mode), .i_dp_dina(i_dp_dina), .i_dp_dinb(i_dp_dinb),
        .i_dp_dinc(i_dp_dinc), .o_dp_vldout(o_dp_vldout), .i_dp_rdy(i_dp_rdy),
        .o_dp_dout(o_dp_dout), .o_dp_busy(o_dp_busy), .o_dp_err(o_dp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] model_lane(input logic [1:0] mode,
                                                 input logic [DW-1:0] a, b, c);
        logic [127:0] ar, br, cr, t;
        ar = 128'(a) % M;
        br = 128'(b) % M;
        cr = ((128'(c) % M) + M - (HALF % M)) % M;
        t  = (((ar + M - cr) % M) * PQ) % M;
        if (mode == 2'd0) t = (t + br) % M;
        if (mode[1]) t = 128'(a[34:0]);
        return t[DW-1:0];
    endfunction

    function automatic word_t model_word(input logic [1:0] mode, input word_t a, b, c);
        word_t w;
        for (int k = 0; k < LN; k++)
            w[k*DW +: DW] = model_lane(mode, a[k*DW +: DW], b[k*DW +: DW], c[k*DW +: DW]);
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int k = 0; k < LN; k++) w[k*DW +: DW] = DW'({$urandom, $urandom});
        return w;
    endfunction

    // Drive one cycle of input; queue the expectation if it will be accepted.
    task automatic drive(input logic v, input logic [1:0] mode, input word_t a, b, c,
                         input word_t exp_w);
        i_dp_vld  = v;
        i_dp_mode = mode;
        i_dp_dina = a;
        i_dp_dinb = b;
        i_dp_dinc = c;
        if (v && o_dp_rdy) sb.push_back(exp_w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_dp_rdy = 1'b1;
        drive(1'b0, 2'd0, W0, W0, W0, W0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (o_dp_vldout !== 1'b0) begin n_fail++; $display("FAIL reset_vldout: got %b want 0", o_dp_vldout); end
        n_cmp++; if (o_dp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_dp_busy); end
        n_cmp++; if (o_dp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_dp_err); end
        n_cmp++; if (o_dp_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", o_dp_rdy); end
    endtask

    // Directed single beats: modes 0/1/2 and the reserved mode 3, with latency check.
    task automatic test_modes();
        word_t av [4], bv [4], cv [4], ev [4];
        logic [1:0] mv [4];
        word_t exp_w;
        int lat;
        av = '{{LN{39'd0}}, {LN{39'd1}}, {LN{39'd123}}, {LN{39'd7}}};
        bv = '{{LN{39'd5}}, {LN{39'd0}}, rand_word(), rand_word()};
        cv = '{{LN{39'h20_0040_0000}}, {LN{39'h20_0040_0000}}, rand_word(), rand_word()};
        ev = '{{LN{39'd5}}, {LN{39'd8_017_516_954}}, {LN{39'd123}}, {LN{39'd7}}};
        mv = '{2'd0, 2'd1, 2'd2, 2'd3};
        i_dp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(1'b1, mv[i], av[i], bv[i], cv[i], ev[i]);
            lat = 0;
            do begin
                @(posedge clk); #1;
                drive(1'b0, 2'd0, W0, W0, W0, W0);
                lat++;
            end while (!o_dp_vldout && lat < 20);
            n_cmp++;
            if (lat != LAT + 1) begin n_fail++; $display("FAIL mode%0d_latency: got %0d want %0d", mv[i], lat, LAT + 1); end
            exp_w = (sb.size() != 0) ? sb.pop_front() : ~ev[i];
            n_cmp++;
            if (o_dp_dout !== exp_w) begin n_fail++; $display("FAIL mode%0d_data: got %h want %h", mv[i], o_dp_dout, exp_w); end
        end
        @(posedge clk); #1;
        n_cmp++; if (o_dp_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", o_dp_err); end
        repeat (100) @(posedge clk);
        #1;
        n_cmp++; if (o_dp_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", o_dp_err); end
    endtask

    // Downstream stalled: exactly DEPTH beats accepted, head held, then ordered drain.
    task automatic test_backpressure();
        word_t a, b, c, exp_w;
        logic [1:0] m;
        int n;
        i_dp_rdy = 1'b0;
        for (int i = 0; i < DEPTH + LAT + 10; i++) begin
            @(posedge clk); #1;
            a = rand_word(); b = rand_word(); c = rand_word(); m = 2'(i % 3);
            drive(1'b1, m, a, b, c, model_word(m, a, b, c));
        end
        n_cmp++; if (sb.size() != DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", sb.size(), DEPTH); end
        n_cmp++; if (o_dp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_low: got %b want 0", o_dp_rdy); end
        n_cmp++; if (o_dp_vldout !== 1'b1 || sb.size() == 0 || o_dp_dout !== sb[0]) begin
            n_fail++; $display("FAIL bp_head_hold: vld %b got %h", o_dp_vldout, o_dp_dout); end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            if (n != 0) begin @(posedge clk); #1; end
            i_dp_rdy = 1'b1;
            drive(1'b0, 2'd0, W0, W0, W0, W0);
            if (o_dp_vldout && i_dp_rdy) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if (o_dp_dout !== exp_w) begin n_fail++; $display("FAIL bp_data: got %h want %h", o_dp_dout, exp_w); end
            end
            n++;
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_timeout: %0d beats missing", sb.size()); end
        @(posedge clk); #1;
        n_cmp++; if (o_dp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_back: got %b want 1", o_dp_rdy); end
        n_cmp++; if (o_dp_busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_clear: got %b want 0", o_dp_busy); end
    endtask

    // Back-to-back beats cycling modes 0/1/2 with random downstream readiness.
    task automatic test_back_to_back();
        word_t a, b, c, exp_w;
        logic [1:0] m;
        int n;
        n = 0;
        while (n < 600 && (n < 60 || sb.size() != 0)) begin
            @(posedge clk); #1;
            i_dp_rdy = (n < 60) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (o_dp_vldout && i_dp_rdy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: unexpected output %h", o_dp_dout);
                end else begin
                    exp_w = sb.pop_front();
                    if (o_dp_dout !== exp_w) begin n_fail++; $display("FAIL b2b_data: got %h want %h", o_dp_dout, exp_w); end
                end
            end
            if (n < 60) begin
                a = rand_word(); b = rand_word(); c = rand_word(); m = 2'(n % 3);
                drive(1'b1, m, a, b, c, model_word(m, a, b, c));
            end else begin
                drive(1'b0, 2'd0, W0, W0, W0, W0);
            end
            n++;
        end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: %0d beats missing", sb.size()); end
    endtask

    // Reset pulsed with five beats in flight: nothing may emerge afterwards.
    task automatic test_mid_reset();
        word_t a;
        int seen;
        i_dp_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            a = rand_word();
            drive(1'b1, 2'd2, a, W0, W0, model_word(2'd2, a, W0, W0));
        end
        @(posedge clk); #1;
        drive(1'b0, 2'd0, W0, W0, W0, W0);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (o_dp_vldout) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_output: got %0d valid cycles want 0", seen); end
        n_cmp++; if (o_dp_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_dp_busy); end
        n_cmp++; if (o_dp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err_clear: got %b want 0", o_dp_err); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
